// File: rtl/load_bin.sv
// load_bin: streams one bin out of the clause, var-bin, var-state and
// lvl-state BRAMs into the SAT engine's load inputs.
// One address per slot is issued per cycle, then a short drain lets the
// two-deep var indirection (var id -> var state) finish before done_load.
// Optional build macro: LOAD_BIN_FREE_VAR_MASK_EN -- when defined, a var id
// of 0 marks an empty slot and that slot's loaded state is forced to 0.
module load_bin #(
  parameter int NUM_CLAUSES_A_BIN      = 8,
  parameter int NUM_VARS_A_BIN         = 8,
  parameter int NUM_LVLS_A_BIN         = 8,
  parameter int WIDTH_CLAUSES          = NUM_VARS_A_BIN * 2,
  parameter int WIDTH_VARS             = 12,
  parameter int WIDTH_LVL              = 16,
  parameter int WIDTH_BIN_ID           = 10,
  parameter int WIDTH_VAR_STATES       = 30,
  parameter int WIDTH_LVL_STATES       = 30,
  parameter int ADDR_WIDTH_CLAUSES     = 9,
  parameter int ADDR_WIDTH_VARS        = 9,
  parameter int ADDR_WIDTH_VARS_STATES = 9,
  parameter int ADDR_WIDTH_LVLS_STATES = 9
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start_load,
  input  logic [WIDTH_BIN_ID-1:0]                     cur_bin_num_i,
  input  logic [WIDTH_LVL-1:0]                        base_lvl_i,
  output logic                                        apply_load_o,
  output logic                                        done_load,
  output logic [NUM_CLAUSES_A_BIN-1:0]                wr_carray_o,
  output logic [WIDTH_CLAUSES-1:0]                    clause_o,
  output logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0]  var_state_o,
  output logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0]  lvl_states_o,
  output logic [ADDR_WIDTH_CLAUSES-1:0]               ram_addr_c_o,
  input  logic [WIDTH_CLAUSES-1:0]                    ram_data_c_i,
  output logic [ADDR_WIDTH_VARS-1:0]                  ram_addr_v_o,
  input  logic [WIDTH_VARS-1:0]                       ram_data_v_i,
  output logic [ADDR_WIDTH_VARS_STATES-1:0]           ram_addr_vs_o,
  input  logic [WIDTH_VAR_STATES-1:0]                 ram_data_vs_i,
  output logic [ADDR_WIDTH_LVLS_STATES-1:0]           ram_addr_l_state_o,
  input  logic [WIDTH_LVL_STATES-1:0]                 ram_data_l_state_i
);

  localparam int N_CV = (NUM_CLAUSES_A_BIN > NUM_VARS_A_BIN) ? NUM_CLAUSES_A_BIN : NUM_VARS_A_BIN;
  localparam int N    = (N_CV > NUM_LVLS_A_BIN) ? N_CV : NUM_LVLS_A_BIN;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(N - 1);
  localparam logic [CW-1:0] C_LAST    = CW'(NUM_CLAUSES_A_BIN - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(NUM_VARS_A_BIN - 1);
  localparam logic [CW-1:0] L_LAST    = CW'(NUM_LVLS_A_BIN - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [1:0]              drain_cnt;
  logic [WIDTH_BIN_ID-1:0] bin_r;
  logic [WIDTH_LVL-1:0]    base_r;

  // slot address to present next cycle
  logic                              issue_s;
  logic [CW-1:0]                     slot_s;
  logic [WIDTH_BIN_ID-1:0]           bin_s;
  logic [WIDTH_LVL-1:0]              base_s;
  logic [ADDR_WIDTH_CLAUSES-1:0]     c_addr_s;
  logic [ADDR_WIDTH_VARS-1:0]        v_addr_s;
  logic [ADDR_WIDTH_LVLS_STATES-1:0] l_addr_s;

  // pipeline: stage 1 address out, stage 2 clause/lvl/var-id data back,
  // stage 3 var-state address out, stage 4 var-state data back
  logic          issue_r;
  logic [CW-1:0] slot_r;
  logic          lvl_valid_r;
  logic          id_valid_r;
  logic [CW-1:0] s2_slot_r;
  logic          vs_valid_r;
  logic [CW-1:0] s3_slot_r;
  logic          st_valid_r;
  logic [CW-1:0] s4_slot_r;
  logic [WIDTH_VAR_STATES-1:0]               var_word_s;
  logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0] lvl_reg;

`ifdef LOAD_BIN_FREE_VAR_MASK_EN
  logic s3_free_r;
  logic s4_free_r;
`else
  logic unused_id_s;
  assign unused_id_s = ^ram_data_v_i;
`endif

  // decode which slot (if any) gets its address on the next clock
  always_comb begin
    issue_s = 1'b0;
    slot_s  = '0;
    bin_s   = bin_r;
    base_s  = base_r;
    case (state)
      IDLE: begin
        if (start_load) begin
          issue_s = 1'b1;
          bin_s   = cur_bin_num_i;
          base_s  = base_lvl_i;
        end else begin
          issue_s = 1'b0;
        end
      end
      ISSUE: begin
        if (cnt != LAST_SLOT) begin
          issue_s = 1'b1;
          slot_s  = cnt + CW'(1);
        end else begin
          issue_s = 1'b0;
        end
      end
      default: issue_s = 1'b0;
    endcase
    c_addr_s = ADDR_WIDTH_CLAUSES'(32'(bin_s) * 32'(NUM_CLAUSES_A_BIN) + 32'(slot_s));
    v_addr_s = ADDR_WIDTH_VARS'(32'(bin_s) * 32'(NUM_VARS_A_BIN) + 32'(slot_s));
    l_addr_s = ADDR_WIDTH_LVLS_STATES'(32'(base_s) + 32'(slot_s));
  end

  // load sequencer: IDLE -> ISSUE (N cycles) -> DRAIN (3 cycles) -> DONE
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      drain_cnt    <= 2'd0;
      bin_r        <= '0;
      base_r       <= '0;
      apply_load_o <= 1'b0;
      done_load    <= 1'b0;
    end else begin
      done_load <= 1'b0;
      case (state)
        IDLE: begin
          if (start_load) begin
            state        <= ISSUE;
            cnt          <= '0;
            bin_r        <= cur_bin_num_i;
            base_r       <= base_lvl_i;
            apply_load_o <= 1'b1;
          end
        end
        ISSUE: begin
          if (cnt == LAST_SLOT) begin
            state     <= DRAIN;
            drain_cnt <= 2'd0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd2) begin
            state     <= DONE;
            done_load <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        DONE: begin
          state        <= IDLE;
          apply_load_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // BRAM read addresses and the per-slot data pipeline
  always_ff @(posedge clk) begin
    if (!rst) begin
      issue_r            <= 1'b0;
      slot_r             <= '0;
      ram_addr_c_o       <= '0;
      ram_addr_v_o       <= '0;
      ram_addr_l_state_o <= '0;
      wr_carray_o        <= '0;
      lvl_valid_r        <= 1'b0;
      id_valid_r         <= 1'b0;
      s2_slot_r          <= '0;
      vs_valid_r         <= 1'b0;
      ram_addr_vs_o      <= '0;
      s3_slot_r          <= '0;
      st_valid_r         <= 1'b0;
      s4_slot_r          <= '0;
`ifdef LOAD_BIN_FREE_VAR_MASK_EN
      s3_free_r          <= 1'b0;
      s4_free_r          <= 1'b0;
`endif
    end else begin
      issue_r            <= issue_s;
      slot_r             <= slot_s;
      ram_addr_c_o       <= (issue_s && slot_s <= C_LAST) ? c_addr_s : '0;
      ram_addr_v_o       <= (issue_s && slot_s <= V_LAST) ? v_addr_s : '0;
      ram_addr_l_state_o <= (issue_s && slot_s <= L_LAST) ? l_addr_s : '0;
      wr_carray_o        <= (issue_r && slot_r <= C_LAST) ?
                            (NUM_CLAUSES_A_BIN'(1) << slot_r) : '0;
      lvl_valid_r        <= issue_r && (slot_r <= L_LAST);
      id_valid_r         <= issue_r && (slot_r <= V_LAST);
      s2_slot_r          <= slot_r;
      vs_valid_r         <= id_valid_r;
      ram_addr_vs_o      <= id_valid_r ? ram_data_v_i[ADDR_WIDTH_VARS_STATES-1:0] : '0;
      s3_slot_r          <= s2_slot_r;
      st_valid_r         <= vs_valid_r;
      s4_slot_r          <= s3_slot_r;
`ifdef LOAD_BIN_FREE_VAR_MASK_EN
      s3_free_r          <= id_valid_r && (ram_data_v_i == '0);
      s4_free_r          <= s3_free_r;
`endif
    end
  end

  // var-state word for the slot whose data is arriving now
  always_comb begin
    var_word_s = ram_data_vs_i;
`ifdef LOAD_BIN_FREE_VAR_MASK_EN
    if (s4_free_r) begin
      var_word_s = '0;
    end else begin
      var_word_s = ram_data_vs_i;
    end
`endif
  end

  // loaded var/lvl state storage: cleared on accepted start, held afterwards
  always_ff @(posedge clk) begin
    if (!rst) begin
      var_state_o <= '0;
      lvl_reg     <= '0;
    end else if (state == IDLE && start_load) begin
      var_state_o <= '0;
      lvl_reg     <= '0;
    end else begin
      if (st_valid_r) begin
        var_state_o[s4_slot_r*WIDTH_VAR_STATES +: WIDTH_VAR_STATES] <= var_word_s;
      end
      if (lvl_valid_r) begin
        lvl_reg[s2_slot_r*WIDTH_LVL_STATES +: WIDTH_LVL_STATES] <= ram_data_l_state_i;
      end
    end
  end

  // lvl slot becomes visible the cycle its BRAM data arrives
  always_comb begin
    lvl_states_o = lvl_reg;
    if (lvl_valid_r) begin
      lvl_states_o[s2_slot_r*WIDTH_LVL_STATES +: WIDTH_LVL_STATES] = ram_data_l_state_i;
    end else begin
      lvl_states_o = lvl_reg;
    end
  end

  // clause word passes straight from the BRAM, qualified by the strobe
  always_comb begin
    clause_o = '0;
    if (|wr_carray_o) begin
      clause_o = ram_data_c_i;
    end else begin
      clause_o = '0;
    end
  end

endmodule
